// File: rtl/disp_scheduler_if.sv
// Bundle between the game logic, the display scheduler and the display mux.
// The scheduler uses the slave side. The producer of the sources and messages
// uses the master side.
interface disp_scheduler_if;
  logic [15:0] src0_val;
  logic [3:0]  src0_dp;
  logic [15:0] src1_val;
  logic [3:0]  src1_dp;
  logic [1:0]  src_en;
  logic        msg_req;
  logic [15:0] msg_val;
  logic [3:0]  msg_dp;
  logic        msg_ack;
  logic        msg_busy;
  logic [3:0]  hex3;
  logic [3:0]  hex2;
  logic [3:0]  hex1;
  logic [3:0]  hex0;
  logic [3:0]  dp_out;
  logic [1:0]  sel;

  modport master (
    output src0_val, src0_dp, src1_val, src1_dp, src_en,
    output msg_req, msg_val, msg_dp,
    input  msg_ack, msg_busy, hex3, hex2, hex1, hex0, dp_out, sel
  );

  modport slave (
    input  src0_val, src0_dp, src1_val, src1_dp, src_en,
    input  msg_req, msg_val, msg_dp,
    output msg_ack, msg_busy, hex3, hex2, hex1, hex0, dp_out, sel
  );
endinterface

// File: rtl/disp_scheduler.sv
// Display scheduler.
// It rotates the 4-digit display between two persistent sources. A one-shot
// message pre-empts the rotation for MSG_CYC cycles, and then the rotation
// resumes. Every output is registered from the next state, so no input has a
// combinational path to an output.
module disp_scheduler #(
  parameter int DWELL_CYC = 100_000_000,
  parameter int MSG_CYC   = 200_000_000,
  parameter int CW        = 28
) (
  input  logic           clk,
  input  logic           reset,
  disp_scheduler_if.slave bus
);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
  localparam logic [CW-1:0] MSG_LAST   = CW'(MSG_CYC - 1);

  typedef enum logic [1:0] {IDLE, SRC0, SRC1, MSG} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  dwell_reg, dwell_next;
  logic [CW-1:0]  timer_reg, timer_next;
  logic           resume_reg, resume_next;
  logic [15:0]    msg_val_reg;
  logic [3:0]     msg_dp_reg;
  logic           accept;
  logic           cur;
  logic           other;
  logic           resume_alt;

  logic [1:0]     sel_reg, sel_next;
  logic [15:0]    digits_reg, digits_next;
  logic [3:0]     dp_reg, dp_next;
  logic           ack_reg;

  // Next-state logic. Accepting a message has priority over every other transition.
  always_comb begin
    state_next  = state_reg;
    dwell_next  = dwell_reg;
    timer_next  = timer_reg;
    resume_next = resume_reg;
    accept      = 1'b0;
    cur         = (state_reg == SRC1);
    other       = ~cur;
    resume_alt  = ~resume_reg;
    case (state_reg)
      IDLE: begin
        if (bus.msg_req) begin
          accept = 1'b1;
        end else if (bus.src_en[0]) begin
          state_next = SRC0;
          dwell_next = '0;
        end else if (bus.src_en[1]) begin
          state_next = SRC1;
          dwell_next = '0;
        end
      end
      SRC0, SRC1: begin
        if (bus.msg_req) begin
          accept      = 1'b1;
          resume_next = cur;
        end else if (!bus.src_en[cur]) begin
          // A disable wins over dwell expiry. The counter restarts for whichever state comes next.
          dwell_next = '0;
          if (bus.src_en[other]) state_next = other ? SRC1 : SRC0;
          else                   state_next = IDLE;
        end else if (dwell_reg == DWELL_LAST) begin
          dwell_next = '0;
          if (bus.src_en[other]) state_next = other ? SRC1 : SRC0;
        end else begin
          dwell_next = dwell_reg + 1'b1;
        end
      end
      MSG: begin
        if (timer_reg != '0) begin
          timer_next = timer_reg - 1'b1;
        end else if (bus.msg_req) begin
          accept = 1'b1;
        end else begin
          dwell_next = '0;
          if (bus.src_en[resume_reg])      state_next = resume_reg ? SRC1 : SRC0;
          else if (bus.src_en[resume_alt]) state_next = resume_alt ? SRC1 : SRC0;
          else                             state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (accept) begin
      state_next = MSG;
      timer_next = MSG_LAST;
    end
  end

  // Output values for the next state. The acceptance cycle bypasses the message latch.
  always_comb begin
    sel_next    = 2'b11;
    digits_next = 16'hFFFF;
    dp_next     = 4'b1111;
    case (state_next)
      SRC0: begin
        sel_next    = 2'b00;
        digits_next = bus.src0_val;
        dp_next     = bus.src0_dp;
      end
      SRC1: begin
        sel_next    = 2'b01;
        digits_next = bus.src1_val;
        dp_next     = bus.src1_dp;
      end
      MSG: begin
        sel_next    = 2'b10;
        digits_next = accept ? bus.msg_val : msg_val_reg;
        dp_next     = accept ? bus.msg_dp  : msg_dp_reg;
      end
      default: begin
        sel_next    = 2'b11;
        digits_next = 16'hFFFF;
        dp_next     = 4'b1111;
      end
    endcase
  end

  // State, counters, message latch and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      dwell_reg   <= '0;
      timer_reg   <= '0;
      resume_reg  <= 1'b0;
      msg_val_reg <= 16'hFFFF;
      msg_dp_reg  <= 4'b1111;
      sel_reg     <= 2'b11;
      digits_reg  <= 16'hFFFF;
      dp_reg      <= 4'b1111;
      ack_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      dwell_reg  <= dwell_next;
      timer_reg  <= timer_next;
      resume_reg <= resume_next;
      if (accept) begin
        msg_val_reg <= bus.msg_val;
        msg_dp_reg  <= bus.msg_dp;
      end
      sel_reg    <= sel_next;
      digits_reg <= digits_next;
      dp_reg     <= dp_next;
      ack_reg    <= accept;
    end
  end

  assign bus.sel      = sel_reg;
  assign bus.hex3     = digits_reg[15:12];
  assign bus.hex2     = digits_reg[11:8];
  assign bus.hex1     = digits_reg[7:4];
  assign bus.hex0     = digits_reg[3:0];
  assign bus.dp_out   = dp_reg;
  assign bus.msg_ack  = ack_reg;
  assign bus.msg_busy = (state_reg == MSG);

endmodule
